// File: rtl/bf_pkg.sv
// Shared definitions for the brainf*** program loader and core.
// Holds the 3-bit opcode encoding, the loader state enum and the loader
// error-cause enum so that the loader and the core agree on every encoding.
package bf_pkg;

    // 3-bit opcode encoding stored in program memory.
    localparam logic [2:0] INC  = 3'b111;  // '+'
    localparam logic [2:0] DEC  = 3'b110;  // '-'
    localparam logic [2:0] MOVR = 3'b101;  // '>'
    localparam logic [2:0] MOVL = 3'b100;  // '<'
    localparam logic [2:0] IF   = 3'b011;  // '['
    localparam logic [2:0] BACK = 3'b010;  // ']'
    localparam logic [2:0] OUT  = 3'b001;  // '.'
    localparam logic [2:0] NOP  = 3'b000;  // terminator: core stalls/halts here

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        ERROR
    } loader_state_e;

    typedef enum logic [1:0] {
        ERR_CAPACITY        = 2'd0,
        ERR_UNMATCHED_CLOSE = 2'd1,
        ERR_TOO_DEEP        = 2'd2,
        ERR_UNMATCHED_OPEN  = 2'd3
    } err_code_e;

endpackage

// File: rtl/bf_program_loader_if.sv
// Bus bundle between a source/host and the program loader.
//   start            : one-cycle pulse beginning a new load
//   in_valid/in_data : ASCII source byte stream, in_ready is the loader's accept
//   prog_we/addr/data: program-memory write port
//   prog_len         : opcodes stored, excluding the terminator
//   done/error/err_code/core_run : load status
// Modport slave is the loader side, master is the host side.
interface bf_program_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [2:0]        prog_data;
    logic [ADDR_W-1:0] prog_len;
    logic              done;
    logic              error;
    logic [1:0]        err_code;
    logic              core_run;

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, prog_we, prog_addr, prog_data, prog_len,
        output done, error, err_code, core_run
    );

    modport master (
        output start, in_valid, in_data,
        input  in_ready, prog_we, prog_addr, prog_data, prog_len,
        input  done, error, err_code, core_run
    );
endinterface

// File: rtl/bf_char_encode.sv
// Combinational source-character classifier.
//   char_in : ASCII byte
//   is_op   : byte is one of the seven program characters
//   is_term : byte is a terminator (0x00 or '!')
//   opcode  : 3-bit opcode for program characters, NOP otherwise
module bf_char_encode
    import bf_pkg::*;
(
    input  logic [7:0] char_in,
    output logic       is_op,
    output logic       is_term,
    output logic [2:0] opcode
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        is_op   = 1'b1;
        is_term = 1'b0;
        opcode  = NOP;
        case (char_in)
            8'h2B:   opcode = INC;   // '+'
            8'h2D:   opcode = DEC;   // '-'
            8'h3E:   opcode = MOVR;  // '>'
            8'h3C:   opcode = MOVL;  // '<'
            8'h5B:   opcode = IF;    // '['
            8'h5D:   opcode = BACK;  // ']'
            8'h2E:   opcode = OUT;   // '.'
            8'h00, 8'h21: begin      // NUL, '!'
                is_op   = 1'b0;
                is_term = 1'b1;
            end
            default: is_op = 1'b0;   // comments and ',' are dropped
        endcase
    end

endmodule

// File: rtl/bf_program_loader.sv
// Loads ASCII brainf*** source into program memory as 3-bit opcodes.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : bf_program_loader_if.slave (byte stream in, memory write
//                port and load status out)
// Brackets are depth-checked during the load; the final memory slot is
// kept for the NOP terminator, so a clean load always ends in NOP.
module bf_program_loader #(
    parameter int ADDR_W   = 8,
    parameter int NEST_MAX = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    bf_program_loader_if.slave bus
);
    import bf_pkg::*;

    localparam int                 DEPTH_W   = $clog2(NEST_MAX + 1);
    localparam logic [ADDR_W-1:0]  CNT_LAST  = '1;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(NEST_MAX);

    loader_state_e      state, state_nxt;
    logic [ADDR_W-1:0]  cnt;
    logic [DEPTH_W-1:0] depth;
    logic               prog_we_q;
    logic [ADDR_W-1:0]  prog_addr_q;
    logic [2:0]         prog_data_q;
    logic [ADDR_W-1:0]  prog_len_q;
    logic               done_q;
    logic               error_q;
    err_code_e          err_code_q;

    logic               is_op, is_term;
    logic [2:0]         opcode;
    logic               ready;
    logic               wr_en, term_wr, cnt_inc, depth_up, depth_dn, err_set;
    logic [2:0]         wr_data;
    err_code_e          err_nxt;

    bf_char_encode u_encode (
        .char_in (bus.in_data),
        .is_op   (is_op),
        .is_term (is_term),
        .opcode  (opcode)
    );

    // start wins over a simultaneous handshake, so the byte is left unconsumed.
    assign ready = (state == LOAD) && !bus.start;

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_data   = NOP;
        term_wr   = 1'b0;
        cnt_inc   = 1'b0;
        depth_up  = 1'b0;
        depth_dn  = 1'b0;
        err_set   = 1'b0;
        err_nxt   = ERR_CAPACITY;
        if (bus.start) begin
            state_nxt = LOAD;
        end else if (ready && bus.in_valid) begin
            if (is_term) begin
                if (depth != '0) begin
                    err_set = 1'b1;
                    err_nxt = ERR_UNMATCHED_OPEN;
                end else begin
                    wr_en   = 1'b1;
                    term_wr = 1'b1;
                end
            end else if (is_op) begin
                if (opcode == BACK && depth == '0) begin
                    err_set = 1'b1;
                    err_nxt = ERR_UNMATCHED_CLOSE;
                end else if (opcode == IF && depth == DEPTH_MAX) begin
                    err_set = 1'b1;
                    err_nxt = ERR_TOO_DEEP;
                end else if (cnt == CNT_LAST) begin
                    // The last slot is held back for the terminator.
                    err_set = 1'b1;
                    err_nxt = ERR_CAPACITY;
                end else begin
                    wr_en    = 1'b1;
                    wr_data  = opcode;
                    cnt_inc  = 1'b1;
                    depth_up = (opcode == IF);
                    depth_dn = (opcode == BACK);
                end
            end
            if (err_set) begin
                state_nxt = ERROR;
            end else if (term_wr) begin
                state_nxt = DONE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            depth       <= '0;
            prog_we_q   <= 1'b0;
            prog_addr_q <= '0;
            prog_data_q <= NOP;
            prog_len_q  <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_CAPACITY;
        end else begin
            state     <= state_nxt;
            prog_we_q <= wr_en;
            if (wr_en) begin
                prog_addr_q <= cnt;
                prog_data_q <= wr_data;
            end
            if (bus.start) begin
                cnt        <= '0;
                depth      <= '0;
                prog_len_q <= '0;
                done_q     <= 1'b0;
                error_q    <= 1'b0;
                err_code_q <= ERR_CAPACITY;
            end else begin
                if (cnt_inc) cnt <= cnt + 1'b1;
                if (depth_up) begin
                    depth <= depth + 1'b1;
                end else if (depth_dn) begin
                    depth <= depth - 1'b1;
                end
                if (term_wr) prog_len_q <= cnt;
                if (err_set) begin
                    error_q    <= 1'b1;
                    err_code_q <= err_nxt;
                end
                // DONE is entered with the terminator write, so done trails
                // that write by exactly one cycle.
                done_q <= (state == DONE);
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.prog_we   = prog_we_q;
    assign bus.prog_addr = prog_addr_q;
    assign bus.prog_data = prog_data_q;
    assign bus.prog_len  = prog_len_q;
    assign bus.done      = done_q;
    assign bus.core_run  = done_q;
    assign bus.error     = error_q;
    assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_bf_program_loader.sv
// Bench for bf_program_loader. Two instances (ADDR_W = 8 and ADDR_W = 4)
// receive the same byte stream; a character-level reference model computes
// the expected write list and final status for each capacity.
module tb_bf_program_loader;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] len;
        logic        done;
        logic        error;
        logic [1:0]  code;
        logic        run;
        logic        rdy;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0] stim[$];
    wr_t        wq[2][$];
    int         acc[2][$];
    int         done_cyc[2];

    // Reference-model results.
    int m_addr[$];
    int m_data[$];
    int m_idx[$];
    int m_used;
    int m_status;  // 0 still loading, 1 done, 2 error
    int m_code;
    int m_len;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bf_program_loader_if #(.ADDR_W(8)) if8 ();
    bf_program_loader_if #(.ADDR_W(4)) if4 ();

    assign if8.start    = start;
    assign if8.in_valid = in_valid;
    assign if8.in_data  = in_data;
    assign if4.start    = start;
    assign if4.in_valid = in_valid;
    assign if4.in_data  = in_data;

    bf_program_loader #(.ADDR_W(8), .NEST_MAX(7)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    bf_program_loader #(.ADDR_W(4), .NEST_MAX(7)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    always @(negedge clk) begin
        wr_t w;
        if (if8.prog_we === 1'b1) begin
            w = '{int'(if8.prog_addr), int'(if8.prog_data), cyc};
            wq[0].push_back(w);
        end
        if (if4.prog_we === 1'b1) begin
            w = '{int'(if4.prog_addr), int'(if4.prog_data), cyc};
            wq[1].push_back(w);
        end
        if (if8.done === 1'b1 && done_cyc[0] < 0) done_cyc[0] = cyc;
        if (if4.done === 1'b1 && done_cyc[1] < 0) done_cyc[1] = cyc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic obs_t snap(input int d);
        obs_t o;
        if (d == 0) begin
            o = '{if8.prog_we, 32'(if8.prog_addr), 32'(if8.prog_data), 32'(if8.prog_len),
                  if8.done, if8.error, if8.err_code, if8.core_run, if8.in_ready};
        end else begin
            o = '{if4.prog_we, 32'(if4.prog_addr), 32'(if4.prog_data), 32'(if4.prog_len),
                  if4.done, if4.error, if4.err_code, if4.core_run, if4.in_ready};
        end
        return o;
    endfunction

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            obs_t o = snap(d);
            string t = $sformatf("%s/dut%0d", tag, d);
            check({t, " prog_we"},   32'(o.we),    0);
            check({t, " prog_addr"}, o.addr,       0);
            check({t, " prog_data"}, o.data,       0);
            check({t, " prog_len"},  o.len,        0);
            check({t, " done"},      32'(o.done),  0);
            check({t, " error"},     32'(o.error), 0);
            check({t, " err_code"},  32'(o.code),  0);
            check({t, " core_run"},  32'(o.run),   0);
            check({t, " in_ready"},  32'(o.rdy),   0);
        end
    endtask

    function automatic int enc(input logic [7:0] c);
        case (c)
            "+": return 7;
            "-": return 6;
            ">": return 5;
            "<": return 4;
            "[": return 3;
            "]": return 2;
            ".": return 1;
            default: return -1;
        endcase
    endfunction

    // Walks the source as a program text: brackets are counted, the memory has
    // 2**aw slots with the last one left for the terminator.
    task automatic model_run(input int aw);
        int cap = 1 << aw;
        int n = 0;
        int depth = 0;
        m_addr.delete(); m_data.delete(); m_idx.delete();
        m_used = stim.size(); m_status = 0; m_code = 0; m_len = 0;
        for (int i = 0; i < stim.size(); i++) begin
            logic [7:0] c = stim[i];
            int op = enc(c);
            if (c == 8'h00 || c == "!") begin
                m_used = i + 1;
                if (depth != 0) begin
                    m_status = 2; m_code = 3;
                end else begin
                    m_addr.push_back(n); m_data.push_back(0); m_idx.push_back(i);
                    m_len = n; m_status = 1;
                end
                break;
            end
            if (op < 0) continue;
            if (c == "]" && depth == 0) begin
                m_status = 2; m_code = 1; m_used = i + 1; break;
            end
            if (c == "[" && depth == 7) begin
                m_status = 2; m_code = 2; m_used = i + 1; break;
            end
            if (n == cap - 1) begin
                m_status = 2; m_code = 0; m_used = i + 1; break;
            end
            m_addr.push_back(n); m_data.push_back(op); m_idx.push_back(i);
            n++;
            if (c == "[") depth++;
            if (c == "]") depth--;
        end
    endtask

    task automatic set_stim(input string s, input bit add_nul);
        stim.delete();
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
        if (add_nul) stim.push_back(8'h00);
    endtask

    task automatic compare(input int d, input string tag);
        obs_t  o = snap(d);
        string t = $sformatf("%s/dut%0d", tag, d);
        int    nw;
        model_run(d == 0 ? 8 : 4);
        check({t, " bytes accepted"}, acc[d].size(), m_used);
        check({t, " write count"}, wq[d].size(), m_addr.size());
        nw = (wq[d].size() < m_addr.size()) ? wq[d].size() : m_addr.size();
        for (int k = 0; k < nw; k++) begin
            check($sformatf("%s wr%0d addr", t, k), wq[d][k].addr, m_addr[k]);
            check($sformatf("%s wr%0d data", t, k), wq[d][k].data, m_data[k]);
            if (m_idx[k] < acc[d].size())
                check($sformatf("%s wr%0d latency", t, k), wq[d][k].cyc, acc[d][m_idx[k]] + 1);
        end
        check({t, " done"},     32'(o.done),  (m_status == 1) ? 1 : 0);
        check({t, " core_run"}, 32'(o.run),   (m_status == 1) ? 1 : 0);
        check({t, " error"},    32'(o.error), (m_status == 2) ? 1 : 0);
        check({t, " err_code"}, 32'(o.code),  (m_status == 2) ? m_code : 0);
        check({t, " prog_len"}, o.len,        (m_status == 1) ? m_len : 0);
        check({t, " in_ready"}, 32'(o.rdy),   (m_status == 0) ? 1 : 0);
        if (m_status == 1 && wq[d].size() > 0)
            check({t, " done delay"}, done_cyc[d], wq[d][wq[d].size()-1].cyc + 1);
    endtask

    // Pulses start with the first byte already offered (it must not be
    // consumed), then streams every byte once with random idle gaps.
    task automatic run_load(input string tag);
        @(negedge clk);
        start    = 1'b1;
        in_valid = (stim.size() > 0);
        in_data  = (stim.size() > 0) ? stim[0] : 8'h00;
        #1;
        check({tag, " in_ready during start dut0"}, 32'(if8.in_ready), 0);
        check({tag, " in_ready during start dut1"}, 32'(if4.in_ready), 0);
        wq[0].delete(); wq[1].delete(); acc[0].delete(); acc[1].delete();
        done_cyc[0] = -1; done_cyc[1] = -1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < stim.size(); i++) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = stim[i];
            #1;
            if (if8.in_ready === 1'b1) acc[0].push_back(cyc);
            if (if4.in_ready === 1'b1) acc[1].push_back(cyc);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        compare(0, tag);
        compare(1, tag);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        string alpha;
        string s;

        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle in_ready dut0", 32'(if8.in_ready), 0);
        check("idle in_ready dut1", 32'(if4.in_ready), 0);

        // Directed programs.
        set_stim("+[->+<].", 1'b1);     run_load("copy_loop");
        check("copy_loop len anchor", 32'(if8.prog_len), 8);
        set_stim("a+ b,\n-!", 1'b0);    run_load("comments");
        set_stim("]", 1'b0);            run_load("early_close");
        set_stim("[[[[[[[[", 1'b0);     run_load("too_deep");
        set_stim("[+", 1'b1);           run_load("open_at_end");

        s = "";
        for (int i = 0; i < 16; i++) s = {s, "+"};
        set_stim(s, 1'b0);              run_load("plus16");
        set_stim(s.substr(0, 14), 1'b1); run_load("plus15_term");

        s = "";
        for (int i = 0; i < 256; i++) s = {s, "+"};
        set_stim(s, 1'b0);              run_load("plus256");
        set_stim(s.substr(0, 254), 1'b1); run_load("plus255_term");

        // Random source text.
        alpha = "+-<>[][]..+,x \n";
        for (int t = 0; t < 25; t++) begin
            int len = $urandom_range(1, 40);
            stim.delete();
            for (int i = 0; i < len; i++) begin
                int r = $urandom_range(0, 39);
                if (r == 0) stim.push_back(8'h21);
                else        stim.push_back(alpha[$urandom_range(0, alpha.len() - 1)]);
            end
            if ($urandom_range(0, 3) != 0) stim.push_back($urandom_range(0, 1) ? 8'h00 : 8'h21);
            run_load($sformatf("rand%0d", t));
        end

        // Asynchronous reset in the middle of a load with in_valid held high.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = "+";
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        wq[0].delete(); wq[1].delete();
        repeat (3) @(negedge clk);
        check("mid_reset writes dut0", wq[0].size(), 0);
        check("mid_reset writes dut1", wq[1].size(), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset idle in_ready dut0", 32'(if8.in_ready), 0);
        check("post_reset idle in_ready dut1", 32'(if4.in_ready), 0);
        check("post_reset writes dut0", wq[0].size(), 0);
        in_valid = 1'b0;
        set_stim("+[->+<].", 1'b1);     run_load("reload");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bf_program_loader.md
BF_PROGRAM_LOADER -- requirements
Module: bf_program_loader

Interface
REQ-001 Parameter ADDR_W, default 8: program-memory address width; capacity is 2**ADDR_W opcodes.
REQ-002 Parameter NEST_MAX, default 7: deepest legal '[' nesting, matching the core's 8-entry PC stack with slot 0 as base.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  one-cycle pulse; begins a new load.
REQ-006 in_valid  in  1  source byte valid.
REQ-007 in_data  in  8  ASCII source byte.
REQ-008 in_ready  out  1  loader accepts a byte when in_valid and in_ready are both 1.
REQ-009 prog_we  out  1  program-memory write strobe.
REQ-010 prog_addr  out  ADDR_W  write address.
REQ-011 prog_data  out  3  encoded opcode.
REQ-012 prog_len  out  ADDR_W  number of opcodes stored, excluding the terminator.
REQ-013 done  out  1  load completed without error (sticky).
REQ-014 error  out  1  load aborted (sticky).
REQ-015 err_code  out  2  error cause: 0 = capacity, 1 = unmatched ']', 2 = nesting too deep, 3 = unmatched '['.
REQ-016 core_run  out  1  releases the core; SHALL be high only while done is high.

Function
REQ-017 The loader SHALL encode source characters as follows: '+' = 111, '-' = 110, '>' = 101, '<' = 100, '[' = 011, ']' = 010, '.' = 001.
REQ-018 Bytes 0x00 and '!' SHALL act as terminators.
REQ-019 All other bytes, including ',', SHALL be accepted and discarded with no write.
REQ-020 The FSM SHALL have the states IDLE, LOAD, DONE and ERROR.
REQ-021 IDLE SHALL move to LOAD on start.
REQ-022 LOAD SHALL move to DONE on an accepted terminator with depth 0.
REQ-023 LOAD SHALL move to ERROR on any error condition.
REQ-024 start in any state SHALL enter LOAD and clear the write counter, the nesting depth, done, error, err_code, core_run and prog_len.
REQ-025 in_ready SHALL be 1 only in LOAD, and SHALL be 0 in the cycle start is sampled.
REQ-026 Writes SHALL be registered with one-cycle latency: a byte accepted in cycle N SHALL produce a one-cycle prog_we pulse in cycle N+1, with prog_addr = counter and the matching prog_data.
REQ-027 The counter SHALL increment by 1 per opcode write.
REQ-028 '[' SHALL increment the depth and ']' SHALL decrement it.
REQ-029 A ']' at depth 0 SHALL raise err_code 1, perform no write, and enter ERROR.
REQ-030 A '[' at depth NEST_MAX SHALL raise err_code 2, perform no write, and enter ERROR.
REQ-031 When the counter equals 2**ADDR_W-1, an opcode byte SHALL raise err_code 0 and enter ERROR, so the last slot is reserved for the terminator.
REQ-032 A terminator SHALL write opcode 000 at the counter address, which the core treats as a stall/halt.
REQ-033 The terminator write SHALL set prog_len = counter and, one cycle after the write, assert done and core_run.
REQ-034 A terminator with depth != 0 SHALL raise err_code 3 and perform no write.
REQ-035 ERROR and DONE SHALL hold in_ready = 0 until start or reset.
REQ-036 The counter SHALL never wrap; it saturates at 2**ADDR_W-1.
REQ-037 start coinciding with an in_valid handshake SHALL take priority, and the byte SHALL NOT be consumed.

Reset
REQ-038 While rst_n = 0, state SHALL be IDLE and every output SHALL be 0, including prog_we, prog_addr, prog_data, prog_len, done, error, err_code, core_run and in_ready.
REQ-039 Reset asserted mid-LOAD SHALL abort the load immediately; no prog_we pulse SHALL occur after assertion.
REQ-040 After deassertion the block SHALL wait in IDLE for start.

Structure
REQ-041 A shared package bf_pkg SHALL hold the 3-bit opcode constants (INC, DEC, MOVR, MOVL, IF, BACK, OUT, NOP), the loader state enum and the err_code enum; the core SHALL use the same package.
REQ-042 A single combinational sub-module bf_char_encode (byte -> {is_op, is_term, opcode}) SHALL be instantiated once.
REQ-043 All other logic SHALL be flat in bf_program_loader.

Verification
REQ-044 start, then bytes "+[->+<]." and 0x00 -> writes at addresses 0..8 = 111,011,110,101,111,100,010,001,000; prog_len = 8; done = 1; core_run = 1.
REQ-045 start, then "a+ b,\n-!" -> writes only 111@0, 110@1, 000@2; prog_len = 2; done = 1.
REQ-046 start, then "]" -> error = 1; err_code = 1; no prog_we; in_ready = 0 thereafter.
REQ-047 start, then 8 × '[' -> the 8th raises err_code 2 after 7 writes of 011; start "[+" plus 0x00 -> err_code 3.
REQ-048 ADDR_W = 4: start, then 16 × '+' -> writes at 0..14, the 16th raises err_code 0; a 15 × '+' plus 0x00 run writes 000@15 with prog_len = 15.
REQ-049 rst_n dropped asynchronously mid-stream with in_valid held high -> all outputs 0 within the same cycle, no further prog_we; after release, start reloads cleanly from address 0.
